// File: rtl/clk_div_bank.sv
// Bank of independent runtime-programmable clock dividers with 50% duty level and tick strobes.
// Optional phase-align input enabled by defining CLK_DIV_BANK_SYNC_EN.
module clk_div_bank #(
  parameter int          CHANNELS    = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 100000,
  parameter int          SEL_W       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic                sync_i,
  output logic [CHANNELS-1:0] clk_o,
  output logic [CHANNELS-1:0] tick_o
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

`ifndef CLK_DIV_BANK_SYNC_EN
  logic unused_sync;
  assign unused_sync = sync_i;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shd;
    logic             pend;
    logic             level;
    logic             tick;
    logic             wr;
    logic             term;

    // Selects at or above CHANNELS never match any channel index, so they are dropped.
    assign wr   = cfg_we && (cfg_sel == SEL_W'(i));
    assign term = (cnt == div);

    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt   <= '0;
        div   <= DIV_RST;
        shd   <= DIV_RST;
        pend  <= 1'b0;
        level <= 1'b0;
        tick  <= 1'b0;
      end
`ifdef CLK_DIV_BANK_SYNC_EN
      else if (sync_i) begin
        cnt   <= '0;
        level <= 1'b0;
        tick  <= 1'b0;
        if (pend) div <= shd;
        pend <= 1'b0;
        if (wr) begin
          shd  <= cfg_div;
          pend <= 1'b1;
        end
      end
`endif
      else begin
        tick <= 1'b0;
        if (en) begin
          if (term) begin
            cnt   <= '0;
            level <= ~level;
            tick  <= 1'b1;
            if (pend) begin
              div  <= shd;
              pend <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // A write landing on the terminal cycle stays pending; the commit above used the old shadow.
        if (wr) begin
          shd  <= cfg_div;
          pend <= 1'b1;
        end
      end
    end

    assign clk_o[i]  = level;
    assign tick_o[i] = tick;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of independent clock dividers for the I/O subsystem. It is the successor to the fixed single-channel segment-scan divider. Each channel has its own runtime-programmable divisor, produces a 50%-duty divided level and a one-cycle tick strobe, and applies divisor changes glitch-free at its terminal count. Consumers are the seven-segment scan, the key debouncer and the LED blink logic, all of which sample `tick_o` as a clock enable in the `clk` domain.

## Interface
- `CHANNELS`, 4: number of divider channels (1..16).
- `CNT_W`, 32: counter and divisor width.
- `DEFAULT_DIV`, 100000: divisor loaded into every channel at reset.
- `SEL_W`, 4: width of `cfg_sel`; must satisfy 2^SEL_W >= CHANNELS.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low.
- `en`  in  1  global count enable.
- `cfg_we`  in  1  divisor write strobe, one cycle.
- `cfg_sel`  in  SEL_W  target channel index.
- `cfg_div`  in  CNT_W  new divisor value.
- `sync_i`  in  1  phase-align all channels (active only with `CLK_DIV_BANK_SYNC_EN`).
- `clk_o`  out  CHANNELS  divided level per channel, registered.
- `tick_o`  out  CHANNELS  one-cycle strobe per channel at terminal count, registered.

## Operation
- Per channel i registers: `cnt[i]`, `div[i]` (active), `shd[i]` (shadow), `pend[i]`.
- Reset (`rst`=0 at a posedge): `cnt`=0, `clk_o`=0, `tick_o`=0, `div`=`shd`=`DEFAULT_DIV`, `pend`=0. Reset takes priority over all other inputs.
- Counting, with `en`=1:
  - If `cnt[i]` < `div[i]`: `cnt[i]` increments and `tick_o[i]`=0.
  - If `cnt[i]` == `div[i]` (terminal): `cnt[i]`<=0, `clk_o[i]` toggles, and `tick_o[i]`<=1. If `pend[i]` is set, `div[i]`<=`shd[i]` and `pend[i]` is cleared.
- Half period is `div`+1 cycles, full period is 2·(`div`+1), and duty is exactly 50%.
- `div`=0: `clk_o` toggles every cycle and `tick_o` is held high.
- `en`=0: `cnt` and `clk_o` hold, and all `tick_o` are 0. Divisor writes are still captured into the shadow registers, but no commit occurs.
- Divisor write: when `cfg_we`=1 and `cfg_sel` < `CHANNELS`, `shd[sel]`<=`cfg_div` and `pend[sel]`<=1. When `cfg_sel` >= `CHANNELS`, the write is ignored.
- Multiple writes before a terminal: the last one wins.
- Write in the same cycle as that channel's terminal: the commit uses the pre-write `shd`. The new value stays pending until the next terminal.
- No comparison against a shrinking divisor can be missed, because `div` changes only when `cnt` returns to 0.
- Counter arithmetic is unsigned, CNT_W bits. `cnt` never exceeds `div`, so no wrap occurs.

## Timing
- After reset release with `en`=1, the first `tick_o[i]` and `clk_o[i]` rise occur on the (`DEFAULT_DIV`+1)th posedge.
- `tick_o` and the `clk_o` edge are coincident, in the same cycle.
- Write-to-effect latency: the new divisor governs the half-period that begins after the next terminal count of the addressed channel.
- `en` takes effect on the next posedge with no extra pipeline stage.
- All outputs are driven from flops; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `CLK_DIV_BANK_SYNC_EN`.
- Defined: `sync_i`=1 at a posedge, regardless of `en`, sets every channel to `cnt`=0, `clk_o`=0, `tick_o`=0. Every pending shadow is committed (`div`<=`shd`, `pend`<=0).
  - A `cfg_we` in the same cycle as `sync_i` updates `shd` and sets `pend` after the commit, so that value waits for the next terminal or sync.
  - `rst` overrides `sync_i`.
- Undefined: `sync_i` is ignored (the port remains; tie it to 0) and no sync logic is synthesised.

## Test plan
- **Reset default:** DEFAULT_DIV=3, CHANNELS=4, `en`=1 after reset → every `clk_o` has period 8 cycles with first rise at posedge 4, and every `tick_o` pulses for one cycle every 4 cycles.
- **Deferred write:** write `cfg_sel`=2, `cfg_div`=1 at cnt=1 → channel 2 completes its current 4-cycle half-period, then uses 2-cycle half-periods. Other channels are unchanged.
- **Write at terminal and div=0:** write ch1 `div`=0 in ch1's terminal cycle → the next half-period still uses 3, after which `clk_o[1]` toggles every cycle and `tick_o[1]` stays high.
- **Enable and out-of-range select:** `en`=0 for 5 cycles mid-count → `cnt` and `clk_o` frozen and `tick_o`=0; counting resumes at the frozen value. A write with `cfg_sel`=5 (CHANNELS=4) → no channel changes.
- **Sync (macro defined):** channels at different phases with ch0 pending `div`=7; pulse `sync_i` → all `clk_o`=0 and `cnt`=0 next cycle. Ch0 then runs with an 8-cycle half-period.
- **Reset mid-operation:** `rst`=0 for 1 cycle while `pend` is set → all outputs 0, divisors back to DEFAULT_DIV, and the pending value is discarded.
